ifetch_queue: RTL and testbench

//  Instruction-fetch front end with a prefetch FIFO, placed directly upstream of the decode stage.

---
 rtl/ifetch_queue.sv | 141 ++++++++++++++
 tb/tb_ifetch_queue.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers in-order
// responses with their PCs, and hands them to decode; a redirect flushes everything.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ready,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       dec_valid,
  output logic [31:0]                dec_instr,
  output logic [31:0]                dec_pc,
  input  logic                       dec_ready,
  output logic [31:0]                fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [31:0]     fetch_pc_r;
  logic [CW-1:0]   outstanding_r, outst_s;
  logic [CW-1:0]   drop_cnt_r, drop_cnt_s, drop_base_s;
  logic [CW-1:0]   count_r, count_s;
  logic [PW-1:0]   rd_ptr_r, wr_ptr_r, tag_rd_r, tag_wr_r;
  logic [31:0]     instr_q_r [DEPTH];
  logic [31:0]     pc_q_r    [DEPTH];
  logic [31:0]     tag_q_r   [DEPTH];
  logic [CW:0]     level_s;
  logic            accept_s, push_s, pop_s;

  // Every queued entry and every in-flight request holds a slot, so a push never overflows.
  assign level_s     = {1'b0, count_r} + {1'b0, outstanding_r};
  assign imem_req    = reset && !redirect && (level_s < DEPTH_L);
  assign accept_s    = imem_req && imem_ready;
  assign push_s      = imem_rvalid && !redirect && (drop_cnt_r == {CW{1'b0}});
  assign pop_s       = (count_r != {CW{1'b0}}) && dec_ready && !redirect;
  assign drop_base_s = outstanding_r - CW'(imem_rvalid);
  assign outst_s     = outstanding_r + CW'(accept_s) - CW'(imem_rvalid);
  assign count_s     = count_r + CW'(push_s) - CW'(pop_s);

  assign imem_addr = fetch_pc_r;
  assign fetch_pc  = fetch_pc_r;
  assign occupancy = count_r;
  assign dec_valid = (count_r != {CW{1'b0}});
  assign dec_instr = instr_q_r[rd_ptr_r];
  assign dec_pc    = pc_q_r[rd_ptr_r];

  // Drain FSM next state: a redirect re-arms the drop count with whatever is still in flight.
  always_comb begin
    state_s    = state_r;
    drop_cnt_s = drop_cnt_r;
    if (redirect) begin
      drop_cnt_s = drop_base_s;
      if (drop_base_s != {CW{1'b0}}) state_s = ST_DRAIN;
      else state_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          state_s = ST_RUN;
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            drop_cnt_s = drop_cnt_r - CW'(1);
            if (drop_cnt_r == CW'(1)) state_s = ST_RUN;
            else state_s = ST_DRAIN;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: begin
          state_s    = ST_RUN;
          drop_cnt_s = {CW{1'b0}};
        end
      endcase
    end
  end

  // Control state: fetch PC, in-flight/drop counters, PC-tag FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      tag_rd_r      <= {PW{1'b0}};
      tag_wr_r      <= {PW{1'b0}};
    end else begin
      state_r       <= state_s;
      drop_cnt_r    <= drop_cnt_s;
      outstanding_r <= outst_s;
      if (redirect) fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      else if (accept_s) fetch_pc_r <= fetch_pc_r + 32'd4;
      else fetch_pc_r <= fetch_pc_r;
      if (accept_s) tag_wr_r <= tag_wr_r + PW'(1);
      else tag_wr_r <= tag_wr_r;
      if (imem_rvalid) tag_rd_r <= tag_rd_r + PW'(1);
      else tag_rd_r <= tag_rd_r;
    end
  end

  // Storage: tag FIFO records the PC of every accepted request; the decode FIFO holds responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_q_r[i] <= 32'h0;
        pc_q_r[i]    <= 32'h0;
        tag_q_r[i]   <= 32'h0;
      end
    end else begin
      if (accept_s) tag_q_r[tag_wr_r] <= fetch_pc_r;
      if (redirect) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (push_s) begin
          instr_q_r[wr_ptr_r] <= imem_rdata;
          pc_q_r[wr_ptr_r]    <= tag_q_r[tag_rd_r];
          wr_ptr_r            <= wr_ptr_r + PW'(1);
        end
        if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
        count_r <= count_s;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: in-order memory model with epoch-tagged
// requests; a negedge monitor scores decode output against the expected stream.
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ready, imem_rvalid, redirect;
  logic        dec_valid, dec_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc, fetch_pc;
  logic [2:0]  occupancy;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .fetch_pc(fetch_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int ready; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mem_q[$];
  ent_t        exp_q[$];
  req_t        cur;
  req_t        nreq;
  ent_t        ent;
  int          n_cmp = 0, n_bad = 0, cyc = 0, epoch = 0, n_out = 0;
  int          max_lat = 1, p_ready = 100, p_dready = 100, p_redir = 0;
  bit          rst_prev = 1'b0;
  logic [31:0] model_pc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit do_reset, input bit do_redir, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    cyc++;
    reset       = !do_reset;
    imem_ready  = ($urandom_range(99) < p_ready);
    dec_ready   = ($urandom_range(99) < p_dready);
    redirect    = !do_reset && (do_redir || ($urandom_range(99) < p_redir));
    redirect_pc = do_redir ? rpc : $urandom;
    if (!do_reset && mem_q.size() > 0 && mem_q[0].ready <= cyc &&
        (max_lat == 1 || $urandom_range(3) != 0)) begin
      cur         = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = cur.data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // Monitor: inputs are stable at negedge, so this cycle's outcome is scored before the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
      if (rst_prev) begin
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
      end
      rst_prev = 1'b1;
      mem_q.delete();
      exp_q.delete();
      n_out    = 0;
      model_pc = 32'h0;
      epoch++;
    end else begin
      rst_prev = 1'b0;
      chk("fetch_pc", fetch_pc, model_pc);
      chk("occupancy", {29'd0, occupancy}, 32'(exp_q.size()));
      chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_q.size() != 0});
      chk("imem_req", {31'd0, imem_req}, {31'd0, !redirect && (exp_q.size() + n_out < DEPTH)});
      if (dec_valid && dec_ready && !redirect && exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        chk("dec_pc", dec_pc, ent.pc);
        chk("dec_instr", dec_instr, ent.instr);
      end
      if (imem_rvalid) begin
        n_out--;
        if (!redirect && cur.epoch == epoch) begin
          ent.pc    = cur.addr;
          ent.instr = cur.data;
          exp_q.push_back(ent);
        end
      end
      if (imem_req && imem_ready) begin
        chk("imem_addr", imem_addr, model_pc);
        nreq.addr  = model_pc;
        nreq.data  = $urandom;
        nreq.epoch = epoch;
        nreq.ready = cyc + $urandom_range(max_lat, 1);
        mem_q.push_back(nreq);
        model_pc = model_pc + 32'd4;
        n_out++;
      end
      if (redirect) begin
        epoch++;
        exp_q.delete();
        model_pc = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    repeat (3) step(1'b1, 1'b0, 32'h0);
    // streaming: always ready, 1-cycle latency
    repeat (30) step(1'b0, 1'b0, 32'h0);
    // decode stalled: queue fills, then fetch stops
    p_dready = 0;
    repeat (20) step(1'b0, 1'b0, 32'h0);
    #1;
    chk("stall_occupancy", {29'd0, occupancy}, 32'd4);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    p_dready = 100;
    step(1'b0, 1'b0, 32'h0);
    p_dready = 0;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    // redirects with requests in flight, second one during drain
    p_dready = 100; max_lat = 3;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    repeat (20) step(1'b0, 1'b0, 32'h0);
    // random traffic
    p_ready = 70; p_dready = 60; p_redir = 5;
    repeat (1500) step(1'b0, 1'b0, 32'h0);
    // address wrap, then reset mid-fetch
    p_redir = 0; p_ready = 100; p_dready = 100; max_lat = 2;
    step(1'b0, 1'b1, 32'hFFFF_FFF3);
    repeat (8) step(1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    repeat (30) step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
